// File: rtl/result_collector.sv
// Packs serial-adder result bytes into 32-bit little-endian words and queues
// them in a CPU-readable FIFO, flagging dropped words and broken framing.
module result_collector #(
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    byte_vld_i,
  input  logic                    byte_lsb_i,
  input  logic                    byte_msb_i,
  input  logic [7:0]              byte_i,
  input  logic                    rd_en_i,
  output logic [31:0]             rd_data_o,
  output logic                    rd_vld_o,
  output logic                    fifo_empty_o,
  output logic                    fifo_full_o,
  output logic [$clog2(DEPTH):0]  word_count_o,
  output logic                    result_done_o,
  output logic                    overflow_o,
  output logic                    proto_err_o
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t      state_reg, state_next;
  logic [31:0] pack_reg, pack_next;
  logic [1:0]  idx_reg, idx_next;
  logic [31:0] base, merged, push_word;
  logic [1:0]  pos;
  logic        push, done_next, proto_set;

  logic [AW:0] wr_ptr_reg, rd_ptr_reg, wr_ptr_next, rd_ptr_next;
  logic [AW:0] count_reg;
  logic        empty_reg, full_reg;
  logic        pop, wr_ok, ovf_set;
  logic [31:0] mem [DEPTH];

  // Packer: a start (from IDLE or a restart on lsb) always rebuilds from byte 0
  always_comb begin
    state_next = state_reg;
    pack_next  = pack_reg;
    idx_next   = idx_reg;
    push       = 1'b0;
    push_word  = pack_reg;
    done_next  = 1'b0;
    proto_set  = 1'b0;
    base       = pack_reg;
    pos        = idx_reg;
    merged     = pack_reg;
    if (byte_vld_i) begin
      if (state_reg == IDLE || byte_lsb_i) begin
        base = 32'd0;
        pos  = 2'd0;
      end
      if (state_reg == COLLECT && byte_lsb_i) proto_set = 1'b1;
      merged = base;
      merged[8*pos +: 8] = byte_i;
      if (byte_msb_i) begin
        push       = 1'b1;
        push_word  = merged;
        pack_next  = 32'd0;
        idx_next   = 2'd0;
        state_next = IDLE;
        done_next  = 1'b1;
      end else if (pos == 2'd3) begin
        push       = 1'b1;
        push_word  = merged;
        pack_next  = 32'd0;
        idx_next   = 2'd0;
        state_next = COLLECT;
      end else begin
        pack_next  = merged;
        idx_next   = pos + 2'd1;
        state_next = COLLECT;
      end
    end
  end

  // A pop frees the slot this same edge, so a push onto a full FIFO still lands
  assign pop         = rd_en_i && !empty_reg;
  assign wr_ok       = push && (!full_reg || pop);
  assign ovf_set     = push && full_reg && !pop;
  assign wr_ptr_next = wr_ok ? wr_ptr_reg + 1'b1 : wr_ptr_reg;
  assign rd_ptr_next = pop ? rd_ptr_reg + 1'b1 : rd_ptr_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      pack_reg      <= 32'd0;
      idx_reg       <= 2'd0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      empty_reg     <= 1'b1;
      full_reg      <= 1'b0;
      rd_data_o     <= 32'd0;
      rd_vld_o      <= 1'b0;
      result_done_o <= 1'b0;
      overflow_o    <= 1'b0;
      proto_err_o   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pack_reg      <= pack_next;
      idx_reg       <= idx_next;
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= wr_ptr_next - rd_ptr_next;
      empty_reg     <= (wr_ptr_next == rd_ptr_next);
      full_reg      <= (wr_ptr_next[AW] != rd_ptr_next[AW]) &&
                       (wr_ptr_next[AW-1:0] == rd_ptr_next[AW-1:0]);
      rd_vld_o      <= pop;
      if (pop) rd_data_o <= mem[rd_ptr_reg[AW-1:0]];
      result_done_o <= done_next;
      if (ovf_set) overflow_o <= 1'b1;
      if (proto_set) proto_err_o <= 1'b1;
    end
  end

  // Storage is deliberately left unreset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_reg[AW-1:0]] <= push_word;
  end

  assign fifo_empty_o = empty_reg;
  assign fifo_full_o  = full_reg;
  assign word_count_o = count_reg;

endmodule

// File: tb/tb_result_collector.sv
// Self-checking bench for result_collector: directed scenarios followed by
// random traffic, all compared against a byte/word queue reference model.
module tb_result_collector;
  localparam int DEPTH = 16;
  localparam int CW = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic byte_vld_i = 1'b0, byte_lsb_i = 1'b0, byte_msb_i = 1'b0, rd_en_i = 1'b0;
  logic [7:0] byte_i = 8'd0;
  logic [31:0] rd_data_o;
  logic rd_vld_o, fifo_empty_o, fifo_full_o, result_done_o, overflow_o, proto_err_o;
  logic [CW-1:0] word_count_o;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0]  cur[$];
  bit          in_res = 1'b0;
  logic [31:0] fq[$];
  logic [31:0] exp_rd_data = 32'd0;
  bit exp_rd_vld = 1'b0, exp_done = 1'b0, exp_ovf = 1'b0, exp_proto = 1'b0;

  result_collector #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .byte_vld_i(byte_vld_i), .byte_lsb_i(byte_lsb_i),
    .byte_msb_i(byte_msb_i), .byte_i(byte_i), .rd_en_i(rd_en_i),
    .rd_data_o(rd_data_o), .rd_vld_o(rd_vld_o), .fifo_empty_o(fifo_empty_o),
    .fifo_full_o(fifo_full_o), .word_count_o(word_count_o),
    .result_done_o(result_done_o), .overflow_o(overflow_o), .proto_err_o(proto_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic model_edge(input bit rst, input bit vld, input bit lsb, input bit msb,
                            input logic [7:0] b, input bit rd);
    bit push;
    logic [31:0] w;
    if (rst) begin
      cur.delete(); fq.delete(); in_res = 1'b0;
      exp_rd_data = 32'd0; exp_rd_vld = 1'b0; exp_done = 1'b0;
      exp_ovf = 1'b0; exp_proto = 1'b0;
      return;
    end
    push = 1'b0; w = 32'd0; exp_done = 1'b0;
    if (vld) begin
      if (lsb && in_res) begin exp_proto = 1'b1; cur.delete(); end
      cur.push_back(b);
      in_res = 1'b1;
      if (msb || cur.size() == 4) begin
        foreach (cur[i]) w = w | (32'(cur[i]) << (8 * i));
        push = 1'b1;
        cur.delete();
        if (msb) begin in_res = 1'b0; exp_done = 1'b1; end
      end
    end
    exp_rd_vld = rd && (fq.size() > 0);
    if (exp_rd_vld) exp_rd_data = fq.pop_front();
    if (push) begin
      if (fq.size() < DEPTH) fq.push_back(w);
      else exp_ovf = 1'b1;
    end
  endtask

  task automatic step(input bit rst, input bit vld, input bit lsb, input bit msb,
                      input logic [7:0] b, input bit rd);
    @(negedge clk);
    rst_n = ~rst; byte_vld_i = vld; byte_lsb_i = lsb; byte_msb_i = msb;
    byte_i = b; rd_en_i = rd;
    @(posedge clk);
    model_edge(rst, vld, lsb, msb, b, rd);
    #1;
    chk("rd_vld", 32'(rd_vld_o), 32'(exp_rd_vld));
    chk("rd_data", rd_data_o, exp_rd_data);
    chk("count", 32'(word_count_o), 32'(fq.size()));
    chk("empty", 32'(fifo_empty_o), 32'(fq.size() == 0));
    chk("full", 32'(fifo_full_o), 32'(fq.size() == DEPTH));
    chk("done", 32'(result_done_o), 32'(exp_done));
    chk("overflow", 32'(overflow_o), 32'(exp_ovf));
    chk("proto_err", 32'(proto_err_o), 32'(exp_proto));
  endtask

  task automatic idle(input bit rd);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, rd);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    bit rnd_vld, rnd_lsb, rnd_msb, rnd_rd;
    // Reset state
    do_reset();
    chk("rst_empty", 32'(fifo_empty_o), 32'd1);
    chk("rst_full", 32'(fifo_full_o), 32'd0);
    chk("rst_count", 32'(word_count_o), 32'd0);
    $display("reset: empty=%0d count=%0d", fifo_empty_o, word_count_o);

    // Six-byte result spanning two words
    step(0, 1, 1, 0, 8'h11, 0);
    step(0, 1, 0, 0, 8'h22, 0);
    step(0, 1, 0, 0, 8'h33, 0);
    step(0, 1, 0, 0, 8'h44, 0);
    chk("six_count1", 32'(word_count_o), 32'd1);
    step(0, 1, 0, 0, 8'h55, 0);
    step(0, 1, 0, 1, 8'h01, 0);
    chk("six_done", 32'(result_done_o), 32'd1);
    chk("six_count2", 32'(word_count_o), 32'd2);
    idle(1);
    chk("six_word0", rd_data_o, 32'h44332211);
    $display("pop: data=%h", rd_data_o);
    idle(1);
    chk("six_word1", rd_data_o, 32'h00000155);
    chk("six_count0", 32'(word_count_o), 32'd0);
    $display("pop: data=%h", rd_data_o);

    // One-byte result, msb only
    step(0, 1, 0, 1, 8'hA5, 0);
    chk("one_done", 32'(result_done_o), 32'd1);
    idle(1);
    chk("one_word", rd_data_o, 32'h000000A5);
    chk("one_proto", 32'(proto_err_o), 32'd0);
    $display("pop: data=%h", rd_data_o);

    // Fill, overflow drop, then push-with-pop while full
    for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 1, 8'(i), 0);
    chk("fill_full", 32'(fifo_full_o), 32'd1);
    step(0, 1, 0, 1, 8'hEE, 0);
    chk("ovf_flag", 32'(overflow_o), 32'd1);
    chk("ovf_count", 32'(word_count_o), 32'(DEPTH));
    step(0, 1, 0, 1, 8'hDD, 1);
    chk("fullpp_count", 32'(word_count_o), 32'(DEPTH));
    chk("fullpp_data", rd_data_o, 32'h00000000);
    $display("full push+pop: count=%0d data=%h", word_count_o, rd_data_o);
    for (int i = 0; i < DEPTH; i++) idle(1);
    chk("drain_last", rd_data_o, 32'h000000DD);
    do_reset();

    // Restart on lsb mid-result
    step(0, 1, 1, 0, 8'hAA, 0);
    step(0, 1, 0, 0, 8'hBB, 0);
    step(0, 1, 1, 0, 8'hCC, 0);
    step(0, 1, 0, 1, 8'hDD, 0);
    chk("restart_proto", 32'(proto_err_o), 32'd1);
    chk("restart_count", 32'(word_count_o), 32'd1);
    idle(1);
    chk("restart_word", rd_data_o, 32'h0000DDCC);
    $display("pop: data=%h", rd_data_o);
    do_reset();

    // Pop on empty, then simultaneous push and pop on empty
    idle(1);
    chk("empty_pop_vld", 32'(rd_vld_o), 32'd0);
    step(0, 1, 0, 1, 8'h77, 1);
    chk("emptypp_count", 32'(word_count_o), 32'd1);
    chk("emptypp_empty", 32'(fifo_empty_o), 32'd0);
    chk("emptypp_vld", 32'(rd_vld_o), 32'd0);

    // Reset mid-result with stored words
    step(0, 1, 0, 1, 8'h01, 0);
    step(0, 1, 1, 0, 8'h02, 0);
    step(0, 1, 0, 0, 8'h03, 0);
    step(0, 1, 0, 0, 8'h04, 0);
    do_reset();
    chk("midrst_empty", 32'(fifo_empty_o), 32'd1);
    chk("midrst_count", 32'(word_count_o), 32'd0);
    chk("midrst_flags", 32'({overflow_o, proto_err_o, result_done_o, rd_vld_o}), 32'd0);
    step(0, 1, 0, 0, 8'h12, 0);
    step(0, 1, 0, 1, 8'h34, 0);
    idle(1);
    chk("midrst_word", rd_data_o, 32'h00003412);
    $display("pop: data=%h", rd_data_o);

    // Random traffic; pop rate alternates so the FIFO both fills and drains
    for (int n = 0; n < 3000; n++) begin
      rnd_vld = ($urandom % 4) != 0;
      rnd_lsb = ($urandom % 6) == 0;
      rnd_msb = ($urandom % 5) == 0;
      rnd_rd  = ((n / 400) % 2 == 0) ? (($urandom % 8) == 0) : (($urandom % 2) == 0);
      if (($urandom % 700) == 0) do_reset();
      else step(0, rnd_vld, rnd_lsb, rnd_msb, 8'($urandom), rnd_rd);
    end
    $display("random: count=%0d overflow=%0d proto=%0d", word_count_o, overflow_o, proto_err_o);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/result_collector.md
RESULT_COLLECTOR -- requirements
Module: result_collector

Interface
REQ-001 Parameter DEPTH, default 16: FIFO depth in 32-bit words; power of two, minimum 2.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 byte_vld_i  input  1  result byte valid from the upstream serial adder; no back-pressure.
REQ-005 byte_lsb_i  input  1  marks the first (least significant) byte of a result; qualified by byte_vld_i.
REQ-006 byte_msb_i  input  1  marks the final carry byte of a result; qualified by byte_vld_i.
REQ-007 byte_i  input  8  result byte data.
REQ-008 rd_en_i  input  1  CPU pop request.
REQ-009 rd_data_o  output  32  popped word, registered.
REQ-010 rd_vld_o  output  1  rd_data_o valid; single-cycle pulse.
REQ-011 fifo_empty_o / fifo_full_o  output  1 each  FIFO status, registered.
REQ-012 word_count_o  output  $clog2(DEPTH)+1  words currently stored.
REQ-013 result_done_o  output  1  single-cycle pulse when a complete result's last word is pushed.
REQ-014 overflow_o  output  1  sticky; a word was dropped because the FIFO was full.
REQ-015 proto_err_o  output  1  sticky; a new result started before the previous one terminated.

Function
REQ-016 Packer FSM states SHALL be IDLE and COLLECT; it SHALL hold a 32-bit pack register and a 2-bit byte index.
REQ-017 IDLE + byte_vld_i: the FSM SHALL start a result, with or without byte_lsb_i, because a one-byte result has no lsb flag upstream.
REQ-018 On start: byte_i goes to pack[7:0], the other bytes are cleared, index becomes 1, and the FSM enters COLLECT.
REQ-019 COLLECT + byte_vld_i without flags: byte_i goes to pack[8*idx+7:8*idx] and idx increments modulo 4.
REQ-020 When a byte fills idx 3, the completed word SHALL be pushed in the same edge, the pack register cleared, and idx set to 0.
REQ-021 byte_msb_i accepted in any state: the byte SHALL be placed at the current idx.
REQ-022 On byte_msb_i the word SHALL be pushed zero-padded above that byte, result_done_o pulses on the next cycle, and the FSM returns to IDLE with idx 0.
REQ-023 byte_lsb_i accepted in COLLECT: the partial word SHALL be discarded unpushed, proto_err_o set, and a new result started per REQ-018.
REQ-024 byte_vld_i low: pack register, idx and FSM SHALL hold.
REQ-025 FIFO: circular buffer with wr_ptr/rd_ptr of $clog2(DEPTH)+1 bits; full when MSBs differ and the rest are equal; empty when the pointers are equal.
REQ-026 A push when full with no pop in the same cycle: the word SHALL be dropped, overflow_o set, and pointers unchanged.
REQ-027 A push when full with a pop in the same cycle SHALL succeed and word_count_o stays at DEPTH.
REQ-028 Pop: rd_en_i with FIFO non-empty drives rd_data_o with the head word and rd_vld_o high at the next edge; 1-cycle latency.
REQ-029 rd_en_i when empty SHALL be ignored: no rd_vld_o, and rd_data_o holds.
REQ-030 Simultaneous push and pop when empty: the pop SHALL be ignored, the push succeeds, and count becomes 1.
REQ-031 word_count_o SHALL change by +1 on push, -1 on pop, and 0 on both; the status outputs reflect the state after the edge.
REQ-032 Pointers SHALL wrap naturally at 2*DEPTH; stored data is not initialised.

Reset
REQ-033 rst_n low at an edge SHALL clear the FSM to IDLE, idx, the pack register, both pointers, rd_data_o, rd_vld_o, result_done_o, overflow_o and proto_err_o to 0.
REQ-034 After reset, fifo_empty_o = 1, fifo_full_o = 0 and word_count_o = 0.
REQ-035 Reset mid-result or with a non-empty FIFO SHALL discard all partial and stored data; rst_n has priority over every other input.

Verification
REQ-036 Push bytes 0x11(lsb),0x22,0x33,0x44,0x55,0x01(msb), then pop twice -> rd_data 0x44332211 then 0x00000155; one result_done pulse; count 2->0.
REQ-037 Single byte 0xA5 with msb only, from IDLE -> one word 0x000000A5, result_done pulse, proto_err_o stays 0.
REQ-038 Fill DEPTH words, push one more with no pop -> word dropped, overflow_o=1, count=DEPTH; repeat with rd_en_i in the same cycle -> accepted, count=DEPTH.
REQ-039 Bytes 0xAA(lsb),0xBB, then 0xCC(lsb),0xDD(msb) -> proto_err_o=1, single word 0x0000DDCC popped.
REQ-040 rd_en_i with FIFO empty -> no rd_vld_o; simultaneous push and pop on empty -> count 1, fifo_empty_o=0.
REQ-041 rst_n low for one cycle after 3 bytes of a result with 2 words stored -> empty=1, count=0, all flags 0; next result packs from byte 0.
